// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch responder: PC, memory req/ack handshake, IR, timeout
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              exec_en,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic              fetch_busy,
    output logic              fetch_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // Last wait-counter value before the request is abandoned.
    localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    // Next-state and registered-output decode for the fetch handshake.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        mem_req_d     = mem_req_q;
        ir_d          = ir_q;
        instr_valid_d = 1'b0;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                if (fetch_en) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    // An ack on the final wait cycle still counts as success.
                    ir_d          = mem_rdata;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(1);
                    mem_req_d     = 1'b0;
                    wait_cnt_d    = 8'd0;
                    state_d       = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the request and hand a NOP to the core.
                    ir_d          = '0;
                    instr_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                    mem_req_d     = 1'b0;
                    wait_cnt_d    = 8'd0;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A taken branch overrides any increment; mem_addr is left alone.
        if (exec_en && branch_taken) begin
            pc_d = branch_target;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= PC_INIT;
            mem_addr_q    <= PC_INIT;
            mem_req_q     <= 1'b0;
            ir_q          <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            ir_q          <= ir_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign ir          = ir_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_busy  = (state_q == S_REQ);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        exec_en;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic        mem_req,     mem_req_b;
    logic [7:0]  mem_addr,    mem_addr_b;
    logic [15:0] ir,          ir_b;
    logic [7:0]  pc,          pc_b;
    logic        instr_valid, instr_valid_b;
    logic        fetch_busy,  fetch_busy_b;
    logic        fetch_err,   fetch_err_b;

    int checks;
    int errors;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .exec_en(exec_en),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir(ir), .pc(pc), .instr_valid(instr_valid),
        .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    fetch_unit #(.TIMEOUT(4)) u_dut_t4 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .exec_en(exec_en),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir(ir_b), .pc(pc_b), .instr_valid(instr_valid_b),
        .fetch_busy(fetch_busy_b), .fetch_err(fetch_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; fetch_en = 1'b0; exec_en = 1'b0; branch_taken = 1'b0;
        branch_target = 8'h00; mem_ack = 1'b0; mem_rdata = 16'h0000;

        // Reset values
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_err", fetch_err, 0);
        tick(); rst_n = 1'b1;
        tick();
        check("idle_valid", instr_valid, 0);

        // First fetch, ack one cycle later
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("f1_req", mem_req, 1);
        check("f1_addr", mem_addr, 8'h00);
        check("f1_busy", fetch_busy, 1);
        check("f1_novalid", instr_valid, 0);
        mem_ack = 1'b1; mem_rdata = 16'h1234; tick(); mem_ack = 1'b0;
        check("f1_ir", ir, 16'h1234);
        check("f1_pc", pc, 8'h01);
        check("f1_valid", instr_valid, 1);
        check("f1_req_drop", mem_req, 0);
        check("f1_busy_drop", fetch_busy, 0);
        tick();
        check("f1_valid_pulse", instr_valid, 0);

        // Ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD; tick(); mem_ack = 1'b0;
        check("idle_ack_valid", instr_valid, 0);
        check("idle_ack_ir", ir, 16'h1234);
        check("idle_ack_req", mem_req, 0);

        // Slow memory: 5 cycles of request, extra fetch_en ignored
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("slow_req0", mem_req, 1);
        check("slow_addr0", mem_addr, 8'h01);
        for (int i = 0; i < 4; i++) begin
            fetch_en = (i == 1);
            tick();
            fetch_en = 1'b0;
            check("slow_req", mem_req, 1);
            check("slow_addr", mem_addr, 8'h01);
            check("slow_busy", fetch_busy, 1);
            check("slow_novalid", instr_valid, 0);
        end
        mem_ack = 1'b1; mem_rdata = 16'hABCD; tick(); mem_ack = 1'b0;
        check("slow_ir", ir, 16'hABCD);
        check("slow_pc", pc, 8'h02);
        check("slow_valid", instr_valid, 1);
        tick();
        check("slow_no_second_req", mem_req, 0);
        check("slow_no_second_busy", fetch_busy, 0);

        // Branch in IDLE
        exec_en = 1'b1; branch_taken = 1'b1; branch_target = 8'h40; tick();
        exec_en = 1'b0; branch_taken = 1'b0;
        check("br_idle_pc", pc, 8'h40);
        check("br_idle_req", mem_req, 0);
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("br_fetch_addr", mem_addr, 8'h40);
        // Branch coinciding with ack wins over increment
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        exec_en = 1'b1; branch_taken = 1'b1; branch_target = 8'h40; tick();
        mem_ack = 1'b0; exec_en = 1'b0; branch_taken = 1'b0;
        check("br_ack_pc", pc, 8'h40);
        check("br_ack_ir", ir, 16'h7777);
        check("br_ack_valid", instr_valid, 1);

        // Fetch and branch together in IDLE: request uses old pc
        tick();
        fetch_en = 1'b1; exec_en = 1'b1; branch_taken = 1'b1; branch_target = 8'h10; tick();
        fetch_en = 1'b0; exec_en = 1'b0; branch_taken = 1'b0;
        check("fb_addr", mem_addr, 8'h40);
        check("fb_pc", pc, 8'h10);
        // Branch during REQ does not disturb mem_addr
        exec_en = 1'b1; branch_taken = 1'b1; branch_target = 8'h20; tick();
        exec_en = 1'b0; branch_taken = 1'b0;
        check("fb_addr_hold", mem_addr, 8'h40);
        check("fb_pc2", pc, 8'h20);
        mem_ack = 1'b1; mem_rdata = 16'h5555; tick(); mem_ack = 1'b0;
        check("fb_pc_inc", pc, 8'h21);

        // Wrap-around
        exec_en = 1'b1; branch_taken = 1'b1; branch_target = 8'hFF; tick();
        exec_en = 1'b0; branch_taken = 1'b0;
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("wrap_addr", mem_addr, 8'hFF);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F; tick(); mem_ack = 1'b0;
        check("wrap_pc", pc, 8'h00);
        check("wrap_ir", ir, 16'h0F0F);

        // Timeout section on the TIMEOUT=4 instance, fresh reset
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        check("t4_rst_err", fetch_err_b, 0);
        // Ack on the 4th request cycle: normal completion
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("t4a_req1", mem_req_b, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4a_req", mem_req_b, 1);
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; tick(); mem_ack = 1'b0;
        check("t4a_valid", instr_valid_b, 1);
        check("t4a_err", fetch_err_b, 0);
        check("t4a_ir", ir_b, 16'hBEEF);
        check("t4a_pc", pc_b, 8'h01);
        tick();
        // No ack: request held exactly 4 cycles
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("t4b_req1", mem_req_b, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4b_req", mem_req_b, 1);
            check("t4b_err_low", fetch_err_b, 0);
        end
        tick();
        check("t4b_req_drop", mem_req_b, 0);
        check("t4b_valid", instr_valid_b, 1);
        check("t4b_err", fetch_err_b, 1);
        check("t4b_ir", ir_b, 16'h0000);
        check("t4b_pc", pc_b, 8'h01);
        check("t4b_busy", fetch_busy_b, 0);
        tick();
        // Good fetch afterwards: error stays sticky
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h4321; tick(); mem_ack = 1'b0;
        check("t4c_ir", ir_b, 16'h4321);
        check("t4c_pc", pc_b, 8'h02);
        check("t4c_err_sticky", fetch_err_b, 1);

        // Reset mid-transaction on the default instance
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        fetch_en = 1'b1; tick(); fetch_en = 1'b0;
        check("mid_busy", fetch_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_async", mem_req, 0);
        check("mid_pc_async", pc, 0);
        check("mid_busy_async", fetch_busy, 0);
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_valid", instr_valid, 0);
            check("mid_no_req", mem_req, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch responder for the FSM-sequenced 16-bit CPU. It acts on the control unit's `fetch_en` / `exec_en` strobes, owns the program counter and runs a req/ack read handshake to instruction memory. It latches the returned word into the instruction register and reports completion, busy and timeout status back to the control and execute paths.

## Interface
- `ADDR_W`, 8: instruction address / PC width.
- `DATA_W`, 16: instruction word width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: maximum cycles `mem_req` is held without `mem_ack`; legal range 1..255.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_en`  in  1  fetch request strobe from the control unit (LOAD state).
- `exec_en`  in  1  execute strobe from the control unit (EXECUTE state).
- `branch_taken`  in  1  qualifies `branch_target`; used only when `exec_en`=1.
- `branch_target`  in  ADDR_W  new PC on a taken branch.
- `mem_req`  out  1  read request to instruction memory, registered.
- `mem_addr`  out  ADDR_W  read address, registered, stable while `mem_req`=1.
- `mem_ack`  in  1  memory response valid; `mem_rdata` is sampled on the same edge.
- `mem_rdata`  in  DATA_W  instruction word.
- `ir`  out  DATA_W  instruction register.
- `pc`  out  ADDR_W  current program counter.
- `instr_valid`  out  1  one-cycle pulse when `ir` has been updated.
- `fetch_busy`  out  1  high while a transaction is outstanding (state REQ).
- `fetch_err`  out  1  sticky timeout flag; only reset clears it.

## Operation
- FSM states:
  - **IDLE**
    - On `fetch_en`=1, go to REQ.
    - Register `mem_req`=1 and `mem_addr`=`pc`.
    - Clear the wait counter.
  - **REQ**
    - Hold `mem_req`=1 and `mem_addr`; increment the wait counter each cycle.
    - On `mem_ack`=1, register `ir`=`mem_rdata`, `instr_valid`=1, `pc`=`pc`+1 and `mem_req`=0, then return to IDLE.
    - If `mem_ack`=0 and the wait counter = `TIMEOUT`-1 (i.e., `TIMEOUT` cycles elapsed), register `ir`=0 (NOP), `instr_valid`=1, `fetch_err`=1 and `mem_req`=0, leave `pc` unchanged, and return to IDLE.
- `fetch_en` while in REQ is ignored; there is no queueing and no error.
- PC arithmetic is modulo 2^ADDR_W: `pc`=2^ADDR_W-1 increments to 0.
- Branch: `exec_en`=1 and `branch_taken`=1 loads `pc`=`branch_target` in any state.
  - If this coincides with a successful `mem_ack`, the branch wins over the increment.
  - `mem_addr` of an in-flight request is never altered.
- Simultaneous `fetch_en` and taken branch in IDLE: the request uses the old `pc`; `pc` takes `branch_target`.
- `mem_ack` in IDLE is ignored.
- `mem_ack` on the timeout cycle counts as success: no error, normal completion.
- `fetch_busy` = (state == REQ), decoded combinationally from the state register.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - state = IDLE, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`.
  - `ir`=0, `mem_req`=0, `instr_valid`=0, `fetch_busy`=0, `fetch_err`=0, wait counter = 0.
- Reset mid-transaction drops `mem_req` immediately, without waiting for a clock edge.
- `fetch_en` sampled at edge N -> `mem_req`=1 from edge N.
- `mem_ack` sampled at edge M -> from edge M:
  - `ir` and `pc` hold their new values.
  - `instr_valid`=1 for exactly one cycle.
  - `mem_req`=0 and `fetch_busy`=0.
- Minimum fetch latency: 2 edges from `fetch_en` to `instr_valid`, with `mem_ack` high on the first REQ cycle.
- A new fetch may be accepted on the edge after `instr_valid` goes high.
- Timeout: if `mem_ack` stays 0, `mem_req` is high for exactly `TIMEOUT` cycles, then `instr_valid` and `fetch_err` rise on the same edge.

## Test plan
- **Reset and first fetch:** hold `rst_n`=0, release; pulse `fetch_en`; memory acks 1 cycle later with 16'h1234 -> `mem_addr`=0 while `mem_req`=1, then `ir`=16'h1234, `pc`=1, one `instr_valid` pulse, all other outputs at reset values beforehand.
- **Slow memory:** ack delayed 5 cycles -> `mem_req` and `mem_addr` stable for all 5 cycles, `fetch_busy`=1 throughout; an extra `fetch_en` during the wait causes no second request.
- **Timeout:** `TIMEOUT`=4, no ack -> `mem_req` high exactly 4 cycles, `ir`=0, `fetch_err`=1 (sticky across later good fetches), `pc` unchanged. Repeat with ack on the 4th cycle -> normal completion, `fetch_err`=0.
- **Branch:** `exec_en`=1, `branch_taken`=1, `branch_target`=8'h40 in IDLE -> `pc`=8'h40, next fetch `mem_addr`=8'h40. Same branch on the ack cycle of an in-flight fetch -> `pc`=8'h40, not old `pc`+1.
- **Wrap-around:** `branch_target`=8'hFF, fetch completes -> `pc`=8'h00.
- **Reset mid-transaction:** drop `rst_n` while in REQ -> `mem_req`=0 with no clock edge, `pc`=`RESET_PC`, no `instr_valid` pulse after reset release until a new `fetch_en`.
